sopc_run_ctrl: RTL and testbench
================================

Name: sopc_run_ctrl

Overview:
- Parametrised run controller for the min-SOPC simulation and FPGA top.
- Sequences reset release into NUM_RST downstream domains (core, bus, peripherals) with a programmable hold and stagger.
- Counts execution cycles and captures a pass/fail code written by the test program.
- Enforces a cycle timeout that puts the SOPC back into reset.
- Replaces fixed-delay reset/stop logic with a reusable, synthesisable block.

Parameters:
- NUM_RST, 2, number of reset output channels (1..8).
- RST_HOLD, 10, cycles all rst_out stay asserted after the internal reset is released (>=1).
- RST_STAGGER, 2, cycles between successive channel releases (0 = release all together).
- SYNC_STAGES, 2, reset-release synchroniser depth (>=2).
- CNT_W, 32, width of cycle_cnt.
- TIMEOUT_CYCLES, 250, RUN-state cycle limit (0 = timeout disabled).
- PASS_CODE, 32'h0000_600D, done_code value that means pass.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- restart, input, 1, synchronous soft restart pulse.
- done_code_vld, input, 1, test program wrote its result code this cycle.
- done_code, input, 32, result code.
- rst_out, output, NUM_RST, per-domain active-high resets.
- cycle_cnt, output, CNT_W, cycles spent in RUN.
- state, output, 3, FSM state.
- done, output, 1, run finished (code or timeout).
- pass, output, 1, done_code matched PASS_CODE.
- timeout, output, 1, run ended by timeout.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, ports clk and rst.
- rst asserts all flops immediately. Asserted reset values:
  - rst_out = all ones
  - cycle_cnt = 0
  - state = HOLD
  - done = pass = timeout = 0
- rst deassertion passes through a SYNC_STAGES flop synchroniser (async set, sync clear). The internal reset drops on the SYNC_STAGES-th rising edge after rst falls.
- FSM encoding: HOLD=0, RELEASE=1, RUN=2, DONE=3, TIMEOUT=4. Other codes are illegal and go to HOLD.
- HOLD:
  - hold counter runs 0..RST_HOLD-1.
  - On the edge where the counter equals RST_HOLD-1: rst_out[0] deasserts and the FSM goes to RELEASE.
  - If NUM_RST==1 or RST_STAGGER==0, all channels deassert on that edge and the FSM goes directly to RUN.
- RELEASE:
  - stagger counter; rst_out[i] deasserts exactly i*RST_STAGGER cycles after rst_out[0].
  - On the edge that releases rst_out[NUM_RST-1], go to RUN.
  - Channels never re-assert out of order; release order is strictly ascending index.
- RUN:
  - cycle_cnt clears on entry, increments by 1 each cycle, and saturates at all ones (no wrap).
  - done_code_vld=1 -> DONE. On the same edge: done=1, pass=(done_code==PASS_CODE), cycle_cnt freezes at its value including that cycle. rst_out stays deasserted.
  - Otherwise, if TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 -> TIMEOUT. On the same edge: done=1, timeout=1, pass=0, and all rst_out reassert.
  - done_code_vld and timeout on the same cycle: the code wins (DONE, timeout=0).
- DONE / TIMEOUT are sticky. Outputs hold and further done_code_vld is ignored.
- done_code_vld in HOLD or RELEASE is ignored.
- restart=1 in any state except HOLD:
  - next edge enters HOLD;
  - all rst_out reassert;
  - done, pass, timeout and cycle_cnt clear;
  - the hold counter restarts from 0.
- restart in HOLD restarts the hold counter.
- restart outranks done_code_vld and timeout on the same edge.
- Async rst mid-operation (any state): immediate return to reset values. Release then repeats the full synchroniser + HOLD + RELEASE sequence.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Defaults, rst high 195 ns then low, 20 ns clk:
  - internal reset drops after 2 edges;
  - rst_out[0] falls 10 cycles later, rst_out[1] falls 2 cycles after that;
  - state reaches RUN (2).
- In RUN, pulse done_code_vld with 32'h0000_600D on RUN cycle 37:
  - done=1, pass=1, timeout=0, cycle_cnt=37 and frozen;
  - rst_out stays 0.
- Same as the previous case but with done_code=32'hBAD0_0001: done=1, pass=0, state=DONE.
- No done_code_vld:
  - after 250 RUN cycles, timeout=1, done=1, state=4, rst_out=2'b11;
  - second variant: done_code_vld on cycle 250 gives DONE with timeout=0.
- NUM_RST=4, RST_STAGGER=3:
  - releases at offsets 0, 3, 6, 9;
  - restart pulse in DONE clears flags and repeats the sequence;
  - rst asserted mid-RELEASE drives all rst_out=1 immediately, without waiting for a clock.
- NUM_RST=1, RST_STAGGER=0, TIMEOUT_CYCLES=0, CNT_W=4: no RELEASE state, cycle_cnt saturates at 15, no timeout ever.

Source files
------------

// File: rtl/sopc_run_ctrl.sv
// Run controller for the min-SOPC: synchronised reset release, staggered per-domain
// reset deassertion, RUN-cycle counting, pass/fail capture and a cycle timeout.
module sopc_run_ctrl #(
   parameter int unsigned NUM_RST        = 2,
   parameter int unsigned RST_HOLD       = 10,
   parameter int unsigned RST_STAGGER    = 2,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 250,
   parameter logic [31:0] PASS_CODE      = 32'h0000_600D
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               restart,
   input  logic               done_code_vld,
   input  logic [31:0]        done_code,
   output logic [NUM_RST-1:0] rst_out,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [2:0]         state,
   output logic               done,
   output logic               pass,
   output logic               timeout
);

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RELEASE = 3'd1,
      S_RUN     = 3'd2,
      S_DONE    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_e;

   localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int unsigned STG_W  = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
   localparam logic [STG_W-1:0]  STG_LAST  = STG_W'((RST_STAGGER > 0) ? RST_STAGGER - 1 : 0);
   localparam bit DIRECT_RUN = (NUM_RST == 1) || (RST_STAGGER == 0);
   // A limit the saturating counter can never reach must not fire through truncation.
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0) &&
                          ((CNT_W >= 32) || ((64'(TIMEOUT_CYCLES) - 64'd1) < (64'd1 << CNT_W)));
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   int_rst;

   state_e              state_q,   state_d;
   logic [HOLD_W-1:0]   hold_q,    hold_d;
   logic [STG_W-1:0]    stg_q,     stg_d;
   logic [NUM_RST-1:0]  rst_out_q, rst_out_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                done_q,    done_d;
   logic                pass_q,    pass_d;
   logic                timeout_q, timeout_d;
   logic [NUM_RST-1:0]  rst_shift;
   logic [CNT_W-1:0]    cnt_inc;

   // NOTE: the synchroniser sets asynchronously but clears only through the clock,
   // so the release edge is always clean with respect to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   assign int_rst = sync_q[SYNC_STAGES-1];

   // NOTE: sequential state uses non-blocking assignments only; all next-state
   // logic lives in the always_comb below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_HOLD;
         hold_q    <= '0;
         stg_q     <= '0;
         rst_out_q <= '1;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         stg_q     <= stg_d;
         rst_out_q <= rst_out_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      stg_d     = stg_q;
      rst_out_d = rst_out_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      rst_shift = rst_out_q << 1;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      if (int_rst || restart) begin
         state_d   = S_HOLD;
         hold_d    = '0;
         stg_d     = '0;
         rst_out_d = '1;
         cnt_d     = '0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  stg_d  = '0;
                  if (DIRECT_RUN) begin
                     rst_out_d = '0;
                     cnt_d     = '0;
                     state_d   = S_RUN;
                  end else begin
                     rst_out_d = rst_shift;
                     state_d   = S_RELEASE;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            // Channels release by shifting zeros in from bit 0: strictly ascending order.
            S_RELEASE: begin
               if (stg_q == STG_LAST) begin
                  stg_d     = '0;
                  rst_out_d = rst_shift;
                  if (rst_shift == '0) begin
                     cnt_d   = '0;
                     state_d = S_RUN;
                  end
               end else begin
                  stg_d = stg_q + 1'b1;
               end
            end
            S_RUN: begin
               cnt_d = cnt_inc;
               if (done_code_vld) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (done_code == PASS_CODE);
               end else if (TO_EN && (cnt_q == TO_LAST)) begin
                  state_d   = S_TIMEOUT;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  pass_d    = 1'b0;
                  rst_out_d = '1;
               end
            end
            S_DONE, S_TIMEOUT: ;
            default: begin
               state_d   = S_HOLD;
               hold_d    = '0;
               stg_d     = '0;
               rst_out_d = '1;
               cnt_d     = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
            end
         endcase
      end
   end

   assign rst_out   = rst_out_q;
   assign cycle_cnt = cnt_q;
   assign state     = state_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl: default build, a 4-channel staggered build and
// a single-channel build with a narrow counter and no timeout.
module tb_sopc_run_ctrl;

   localparam logic [31:0] PASS = 32'h0000_600D;
   localparam logic [31:0] BAD  = 32'hBAD0_0001;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst_a = 1'b0, restart_a = 1'b0, vld_a = 1'b0;
   logic [31:0] code_a = '0;
   logic [1:0]  rst_out_a;
   logic [31:0] cnt_a;
   logic [2:0]  state_a;
   logic        done_a, pass_a, to_a;

   logic        rst_b = 1'b0, restart_b = 1'b0, vld_b = 1'b0;
   logic [31:0] code_b = '0;
   logic [3:0]  rst_out_b;
   logic [31:0] cnt_b;
   logic [2:0]  state_b;
   logic        done_b, pass_b, to_b;

   logic        rst_c = 1'b0, restart_c = 1'b0, vld_c = 1'b0;
   logic [31:0] code_c = '0;
   logic [0:0]  rst_out_c;
   logic [3:0]  cnt_c;
   logic [2:0]  state_c;
   logic        done_c, pass_c, to_c;

   sopc_run_ctrl dut_a (
      .clk(clk), .rst(rst_a), .restart(restart_a), .done_code_vld(vld_a), .done_code(code_a),
      .rst_out(rst_out_a), .cycle_cnt(cnt_a), .state(state_a), .done(done_a), .pass(pass_a),
      .timeout(to_a)
   );

   sopc_run_ctrl #(.NUM_RST(4), .RST_STAGGER(3)) dut_b (
      .clk(clk), .rst(rst_b), .restart(restart_b), .done_code_vld(vld_b), .done_code(code_b),
      .rst_out(rst_out_b), .cycle_cnt(cnt_b), .state(state_b), .done(done_b), .pass(pass_b),
      .timeout(to_b)
   );

   sopc_run_ctrl #(.NUM_RST(1), .RST_STAGGER(0), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_c (
      .clk(clk), .rst(rst_c), .restart(restart_c), .done_code_vld(vld_c), .done_code(code_c),
      .rst_out(rst_out_c), .cycle_cnt(cnt_c), .state(state_c), .done(done_c), .pass(pass_c),
      .timeout(to_c)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int fb[4];
   int rb;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run_a(output int n);
      n = 0;
      while (state_a != 3'd2 && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Edge index (1-based) at which each channel falls and RUN is reached.
   task automatic measure_b();
      for (int i = 0; i < 4; i++) fb[i] = 0;
      rb = 0;
      for (int e = 1; e <= 40 && rb == 0; e++) begin
         tick();
         for (int i = 0; i < 4; i++)
            if (fb[i] == 0 && !rst_out_b[i]) fb[i] = e;
         if (state_b == 3'd2) rb = e;
      end
   endtask

   initial begin
      int e0, e1, er, n, rc;
      bit saw_rel;

      #1;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      #4;
      check("a_rst_out_reset", rst_out_a, 2'b11);
      check("a_state_reset",   state_a,   3'd0);
      check("a_cnt_reset",     cnt_a,     0);
      check("a_flags_reset",   {done_a, pass_a, to_a}, 3'b000);

      // ---- default build: release timing ----
      #190;
      rst_a = 1'b0;
      e0 = 0; e1 = 0; er = 0;
      for (int e = 1; e <= 40 && er == 0; e++) begin
         tick();
         if (e0 == 0 && !rst_out_a[0]) e0 = e;
         if (e1 == 0 && !rst_out_a[1]) e1 = e;
         if (state_a == 3'd2) er = e;
      end
      check("a_rel0_edge", e0, 12);
      check("a_rel1_edge", e1, 14);
      check("a_run_edge",  er, 14);

      // ---- pass code on RUN cycle 37 ----
      repeat (36) tick();
      check("a_cnt_cycle37", cnt_a, 36);
      code_a = PASS; vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      check("a_pass_state", state_a, 3'd3);
      check("a_pass_flags", {done_a, pass_a, to_a}, 3'b110);
      check("a_pass_cnt",   cnt_a, 37);
      check("a_pass_rstout", rst_out_a, 2'b00);
      code_a = BAD; vld_a = 1'b1;
      repeat (5) tick();
      vld_a = 1'b0;
      check("a_done_sticky_cnt",  cnt_a, 37);
      check("a_done_sticky_pass", pass_a, 1'b1);

      // ---- restart from DONE ----
      restart_a = 1'b1;
      tick();
      restart_a = 1'b0;
      check("a_restart_state",  state_a, 3'd0);
      check("a_restart_rstout", rst_out_a, 2'b11);
      check("a_restart_flags",  {done_a, pass_a, to_a}, 3'b000);
      check("a_restart_cnt",    cnt_a, 0);
      wait_run_a(n);
      check("a_restart_to_run", n, 12);

      // ---- fail code ----
      repeat (4) tick();
      code_a = BAD; vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      check("a_fail_state", state_a, 3'd3);
      check("a_fail_flags", {done_a, pass_a, to_a}, 3'b100);
      check("a_fail_cnt",   cnt_a, 5);

      // ---- restart outranks done_code_vld ----
      restart_a = 1'b1; tick(); restart_a = 1'b0;
      wait_run_a(n);
      restart_a = 1'b1; code_a = PASS; vld_a = 1'b1;
      tick();
      restart_a = 1'b0; vld_a = 1'b0;
      check("a_restart_wins_state", state_a, 3'd0);
      check("a_restart_wins_done",  done_a, 1'b0);

      // ---- timeout after 250 RUN cycles ----
      wait_run_a(n);
      repeat (249) tick();
      check("a_to_pre_state", state_a, 3'd2);
      check("a_to_pre_cnt",   cnt_a, 249);
      tick();
      check("a_to_state",  state_a, 3'd4);
      check("a_to_flags",  {done_a, pass_a, to_a}, 3'b101);
      check("a_to_rstout", rst_out_a, 2'b11);
      code_a = PASS; vld_a = 1'b1;
      repeat (3) tick();
      vld_a = 1'b0;
      check("a_to_sticky", {state_a, pass_a}, {3'd4, 1'b0});

      // ---- code on the timeout cycle wins ----
      restart_a = 1'b1; tick(); restart_a = 1'b0;
      wait_run_a(n);
      repeat (249) tick();
      code_a = PASS; vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      check("a_code_vs_to_state", state_a, 3'd3);
      check("a_code_vs_to_flags", {done_a, pass_a, to_a}, 3'b110);
      check("a_code_vs_to_cnt",   cnt_a, 250);
      check("a_code_vs_to_rstout", rst_out_a, 2'b00);

      // ---- 4 channels, stagger 3 ----
      tick();
      rst_b = 1'b0;
      measure_b();
      check("b_rel0_edge", fb[0], 12);
      for (int i = 1; i < 4; i++) check($sformatf("b_rel%0d_offset", i), fb[i] - fb[0], 3 * i);
      check("b_run_edge", rb, 21);
      code_b = PASS; vld_b = 1'b1;
      tick();
      vld_b = 1'b0;
      check("b_done_state", {state_b, done_b, pass_b}, {3'd3, 1'b1, 1'b1});
      restart_b = 1'b1;
      tick();
      restart_b = 1'b0;
      check("b_restart_state",  state_b, 3'd0);
      check("b_restart_rstout", rst_out_b, 4'hF);
      check("b_restart_flags",  {done_b, pass_b, to_b}, 3'b000);
      measure_b();
      check("b_rr_rel0_edge", fb[0], 10);
      for (int i = 1; i < 4; i++) check($sformatf("b_rr_rel%0d_offset", i), fb[i] - fb[0], 3 * i);
      check("b_rr_run_edge", rb, 19);

      // ---- async rst mid-RELEASE ----
      restart_b = 1'b1; tick(); restart_b = 1'b0;
      n = 0;
      while (state_b != 3'd1 && n < 40) begin
         tick();
         n++;
      end
      check("b_reach_release", n, 10);
      #5;
      rst_b = 1'b1;
      #1;
      check("b_async_rstout", rst_out_b, 4'hF);
      check("b_async_state",  state_b, 3'd0);
      tick(); tick();
      rst_b = 1'b0;
      measure_b();
      check("b_async_rel0_edge", fb[0], 12);
      check("b_async_run_edge",  rb, 21);

      // ---- single channel, no stagger, no timeout, 4-bit counter ----
      rst_c = 1'b0;
      rc = 0; saw_rel = 1'b0;
      for (int e = 1; e <= 40 && rc == 0; e++) begin
         tick();
         if (state_c == 3'd1) saw_rel = 1'b1;
         if (state_c == 3'd2) rc = e;
      end
      check("c_run_edge",   rc, 12);
      check("c_no_release", saw_rel, 1'b0);
      check("c_rstout_run", rst_out_c, 1'b0);
      repeat (15) tick();
      check("c_cnt_15", cnt_c, 4'd15);
      repeat (300) tick();
      check("c_cnt_sat",   cnt_c, 4'd15);
      check("c_no_timeout", {state_c, done_c, to_c}, {3'd2, 1'b0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
